sale_fsm_param: RTL

Parametrised next-generation sale-terminal controller. Sequences START/IDLE/BARCODE/INTERACTIVE/QUANTITY/EDIT/CHECKOUT/ERROR. It owns the barcode digit shift register and emits single-cycle command pulses directly, so no external level-to-pulse converters are needed. It also adds configurable barcode length, additive quantity entry, an inactivity timeout and a timed error state. It sits between the button/switch debouncers and the barcode lookup, cursor and basket controllers.

---
 rtl/sale_pkg.sv | 38 +++
 rtl/barcode_shift_reg.sv | 45 ++++
 rtl/sale_fsm_param.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sale_pkg.sv
// Shared encodings for the sale-terminal controller: state codes, command bit indices, cursor directions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sale_pkg;

    localparam logic [2:0] ST_START_C       = 3'd0;
    localparam logic [2:0] ST_IDLE_C        = 3'd1;
    localparam logic [2:0] ST_BARCODE_C     = 3'd2;
    localparam logic [2:0] ST_INTERACTIVE_C = 3'd3;
    localparam logic [2:0] ST_QUANTITY_C    = 3'd4;
    localparam logic [2:0] ST_EDIT_C        = 3'd5;
    localparam logic [2:0] ST_CHECKOUT_C    = 3'd6;
    localparam logic [2:0] ST_ERROR_C       = 3'd7;

    typedef enum logic [2:0] {
        ST_START       = ST_START_C,
        ST_IDLE        = ST_IDLE_C,
        ST_BARCODE     = ST_BARCODE_C,
        ST_INTERACTIVE = ST_INTERACTIVE_C,
        ST_QUANTITY    = ST_QUANTITY_C,
        ST_EDIT        = ST_EDIT_C,
        ST_CHECKOUT    = ST_CHECKOUT_C,
        ST_ERROR       = ST_ERROR_C
    } state_t;

    localparam int CMD_END    = 0;
    localparam int CMD_CANCEL = 1;
    localparam int CMD_SELECT = 3;

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // Sliced down to the product ID width by the user.
    localparam logic [31:0] NO_PRODUCT = '1;

endpackage

// File: rtl/barcode_shift_reg.sv
// Nibble shift register holding the typed barcode, newest digit in [3:0], with a saturating digit count.
// Latency: 1 cycle from clr/shift to outputs.
// Backpressure: none; shifts are dropped once DIGITS digits are held, clr wins over shift.
module barcode_shift_reg #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  shift_vld,
    input  logic [3:0]            digit_dat,
    output logic [4*DIGITS-1:0]   barcode_dat,
    output logic [CNT_W-1:0]      count
);
    localparam int BC_W = 4 * DIGITS;

    logic [BC_W-1:0]  bc_q, bc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        bc_d  = bc_q;
        cnt_d = cnt_q;
        if (clr) begin
            bc_d  = '0;
            cnt_d = '0;
        end else if (shift_vld && (cnt_q < CNT_W'(DIGITS))) begin
            bc_d  = (bc_q << 4) | BC_W'(digit_dat);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bc_q  <= '0;
            cnt_q <= '0;
        end else begin
            bc_q  <= bc_d;
            cnt_q <= cnt_d;
        end
    end

    assign barcode_dat = bc_q;
    assign count       = cnt_q;
endmodule

// File: rtl/sale_fsm_param.sv
// Sale-terminal controller: barcode/cursor product selection, quantity entry, basket edit, checkout, timed error.
// Latency: every output registered, reacting one cycle after the input pulse.
// Backpressure: none; pulses not meaningful in the current state (or in ERROR) are dropped.
module sale_fsm_param
    import sale_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int KEYS    = 4,
    parameter int ID_W    = 4,
    parameter int QTY_MAX = 9,
    parameter int TIMEOUT = 50_000_000,
    parameter int ERR_CYC = 25_000_000
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET,
    input  logic [KEYS-1:0]              KEY_Pulse,
    input  logic [3:0]                   CMD_Pulse,
    input  logic [1:0]                   Mode_SW,
    input  logic [ID_W-1:0]              Lookup_ID,
    input  logic                         Lookup_Valid,
    input  logic [ID_W-1:0]              Cursor_ID,
    input  logic [3:0]                   BasketProductNum,
    output logic [4*DIGITS-1:0]          Barcode_out,
    output logic [$clog2(DIGITS+1)-1:0]  Barcode_Count,
    output logic [2:0]                   State_out,
    output logic [ID_W-1:0]              ProductID_out,
    output logic [3:0]                   ProductQuantity,
    output logic [1:0]                   Cursor_Dir,
    output logic                         Cursor_Move_Pulse,
    output logic                         Cursor_Reset_Pulse,
    output logic                         Basket_Add_Pulse,
    output logic                         Basket_Cancel_Pulse,
    output logic                         Checkout_Pulse,
    output logic                         Error_out
);
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 2);
    localparam int ERR_W = $clog2(ERR_CYC + 2);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'((ERR_CYC > 0) ? ERR_CYC - 1 : 0);
    localparam logic [4:0]       QTY_CAP  = 5'(QTY_MAX);
    localparam logic [ID_W-1:0]  NO_PROD  = NO_PRODUCT[ID_W-1:0];

    state_t           state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [3:0]       qty_q, qty_d;
    logic [1:0]       dir_q, dir_d;
    logic             move_q, move_d, creset_q, creset_d, add_q, add_d;
    logic             bcancel_q, bcancel_d, chk_q, chk_d, err_flag_q, err_flag_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic             bc_clr, bc_shift;
    logic [CNT_W-1:0] bc_cnt;
    logic             key_any, cmd_end, cmd_cancel, cmd_sel, timeout_hit;
    logic [3:0]       key_val;
    logic [1:0]       key_dir;
    logic [4:0]       qty_sum;

    // Lowest-index key wins when several arrive together.
    always_comb begin
        key_val = '0;
        key_dir = '0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (KEY_Pulse[i]) begin
                key_val = 4'(KEYS - i);
                key_dir = 2'(KEYS - 1 - i);
            end
        end
    end

    assign key_any    = |KEY_Pulse;
    assign cmd_end    = CMD_Pulse[CMD_END];
    assign cmd_cancel = CMD_Pulse[CMD_CANCEL];
    assign cmd_sel    = CMD_Pulse[CMD_SELECT];
    assign qty_sum    = {1'b0, qty_q} + {1'b0, key_val};
    assign timeout_hit = (TIMEOUT != 0) && (timer_q >= TMO_LAST) &&
                         (state_q inside {ST_BARCODE, ST_INTERACTIVE, ST_QUANTITY,
                                          ST_EDIT, ST_CHECKOUT});

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        qty_d     = qty_q;
        dir_d     = dir_q;
        move_d    = 1'b0;
        creset_d  = 1'b0;
        add_d     = 1'b0;
        bcancel_d = 1'b0;
        chk_d     = 1'b0;
        bc_clr    = 1'b0;
        bc_shift  = 1'b0;
        if (timeout_hit) begin
            state_d = ST_IDLE;
            bc_clr  = 1'b1;
            qty_d   = '0;
        end else begin
            case (state_q)
                ST_START: begin
                    bc_clr   = 1'b1;
                    qty_d    = '0;
                    id_d     = NO_PROD;
                    creset_d = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_IDLE: begin
                    if (cmd_sel) begin
                        state_d = ST_CHECKOUT;
                    end else if (Mode_SW[1]) begin
                        state_d  = ST_EDIT;
                        creset_d = 1'b1;
                    end else if (Mode_SW[0]) begin
                        state_d  = ST_INTERACTIVE;
                        creset_d = 1'b1;
                    end else begin
                        state_d = ST_BARCODE;
                    end
                end
                ST_BARCODE: begin
                    if (|Mode_SW) begin
                        bc_clr  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (cmd_end) begin
                        state_d = ST_CHECKOUT;
                    end else if (cmd_cancel) begin
                        bc_clr = 1'b1;
                    end else if (cmd_sel && (bc_cnt == CNT_W'(DIGITS))) begin
                        if (Lookup_Valid) begin
                            id_d    = Lookup_ID;
                            state_d = ST_QUANTITY;
                        end else begin
                            bc_clr  = 1'b1;
                            state_d = ST_ERROR;
                        end
                    end else if (key_any) begin
                        bc_shift = 1'b1;
                    end
                end
                ST_INTERACTIVE: begin
                    if (Mode_SW[1]) begin
                        state_d = ST_EDIT;
                    end else if (!Mode_SW[0]) begin
                        state_d = ST_IDLE;
                    end else if (cmd_end) begin
                        state_d = ST_CHECKOUT;
                    end else if (cmd_sel) begin
                        id_d    = Cursor_ID;
                        state_d = ST_QUANTITY;
                    end else if (key_any) begin
                        move_d = 1'b1;
                        dir_d  = key_dir;
                    end
                end
                ST_QUANTITY: begin
                    if (cmd_cancel) begin
                        bc_clr  = 1'b1;
                        qty_d   = '0;
                        state_d = ST_IDLE;
                    end else if (cmd_sel) begin
                        if (qty_q != '0) begin
                            add_d   = 1'b1;
                            bc_clr  = 1'b1;
                            qty_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end else if (key_any) begin
                        qty_d = (qty_sum > QTY_CAP) ? QTY_CAP[3:0] : qty_sum[3:0];
                    end
                end
                ST_EDIT: begin
                    if (!Mode_SW[1]) begin
                        creset_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (cmd_end) begin
                        state_d = ST_CHECKOUT;
                    end else if (cmd_sel) begin
                        id_d      = Cursor_ID;
                        bcancel_d = 1'b1;
                    end else if (key_any && (key_dir == DIR_UP || key_dir == DIR_DOWN)) begin
                        move_d = 1'b1;
                        dir_d  = key_dir;
                    end
                end
                ST_CHECKOUT: begin
                    if (cmd_cancel) begin
                        state_d = ST_IDLE;
                    end else if (BasketProductNum == 4'd0) begin
                        state_d = ST_ERROR;
                    end else if (cmd_end) begin
                        chk_d   = 1'b1;
                        state_d = ST_START;
                    end
                end
                ST_ERROR: begin
                    bc_clr = 1'b1;
                    if (err_q >= ERR_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_START;
            endcase
        end
    end

    always_comb begin
        err_flag_d = (state_d == ST_ERROR);
        err_d      = '0;
        if (state_q == ST_ERROR && state_d == ST_ERROR) begin
            err_d = err_q + ERR_W'(1);
        end
        timer_d = timer_q;
        if (key_any || (|CMD_Pulse) || (state_d != state_q)) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q    <= ST_START;
            id_q       <= NO_PROD;
            qty_q      <= '0;
            dir_q      <= '0;
            move_q     <= 1'b0;
            creset_q   <= 1'b0;
            add_q      <= 1'b0;
            bcancel_q  <= 1'b0;
            chk_q      <= 1'b0;
            err_flag_q <= 1'b0;
            timer_q    <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            qty_q      <= qty_d;
            dir_q      <= dir_d;
            move_q     <= move_d;
            creset_q   <= creset_d;
            add_q      <= add_d;
            bcancel_q  <= bcancel_d;
            chk_q      <= chk_d;
            err_flag_q <= err_flag_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
        end
    end

    barcode_shift_reg #(.DIGITS(DIGITS), .CNT_W(CNT_W)) u_barcode (
        .clk         (CLOCK_50),
        .rst         (RESET),
        .clr         (bc_clr),
        .shift_vld   (bc_shift),
        .digit_dat   (key_val),
        .barcode_dat (Barcode_out),
        .count       (bc_cnt)
    );

    assign Barcode_Count       = bc_cnt;
    assign State_out           = state_q;
    assign ProductID_out       = id_q;
    assign ProductQuantity     = qty_q;
    assign Cursor_Dir          = dir_q;
    assign Cursor_Move_Pulse   = move_q;
    assign Cursor_Reset_Pulse  = creset_q;
    assign Basket_Add_Pulse    = add_q;
    assign Basket_Cancel_Pulse = bcancel_q;
    assign Checkout_Pulse      = chk_q;
    assign Error_out           = err_flag_q;
endmodule
